unified_buffer_write_control_unit: RTL and testbench
====================================================

# unified_buffer_write_control_unit

Write-back controller that takes quantized output rows from the accumulator drain path and writes them into the unified buffer at tile-ordered addresses. It is the write side of the unified buffer and the counterpart of the read-side address generator. For every output tile column it writes U_dim rows, then moves on. An optional skid FIFO absorbs unified-buffer port back-pressure.

## Interface
- DATA_W, 256, width of one output row (32 lanes × 8 bit)
- FIFO_DEPTH, 4, skid FIFO entries (power of two, ≥2); only used when the FIFO is compiled in
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; latches the job fields below; ignored while busy_o=1
- start_addr_i  in  12  unified buffer address of the first output row
- U_dim1_i  in  7  output rows minus 1 (1..128 rows)
- ITER_dim1_i  in  7  output columns minus 1; tile columns = (ITER_dim1_i>>5)+1 (1..4)
- acc_valid_i  in  1  accumulator row valid
- acc_data_i  in  DATA_W  accumulator row data
- acc_ready_o  out  1  row accepted when acc_valid_i & acc_ready_o
- ub_wr_ready_i  in  1  unified buffer write port granted this cycle
- ub_wr_en_o  out  1  write strobe; a write is committed when ub_wr_en_o & ub_wr_ready_i
- ub_wr_addr_o  out  12  write address
- ub_wr_data_o  out  DATA_W  write data
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse when the job's last write is committed

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - acc_ready_o=0, ub_wr_en_o=0.
  - start_i latches start_addr_i, U_dim1_i and ITER_dim1_i, clears the counters, and goes to WRITE.
- WRITE:
  - Accepts rows while acc_ready_o=1.
  - Per committed write, row_q increments.
  - When row_q==U_dim1_q, row_q returns to 0 and tile_x_q increments.
  - When tile_x_q==(ITER_dim1_q>>5) and row_q==U_dim1_q, that commit is the last; go to DONE.
- Addressing: ub_wr_addr_o = start_addr_q + tile_x_q*(U_dim1_q+1) + row_q, computed 12-bit and wrapping modulo 4096.
- Total writes per job = (U_dim1+1)×((ITER_dim1>>5)+1).
- Acceptance limit: rows are accepted only while accepted_count < total writes. Extra acc_valid_i beyond the job total is never accepted.
- DONE: done_o=1 for one cycle, busy_o drops, return to IDLE.
- busy_o=1 in WRITE and DONE.
- A start_i arriving in DONE is ignored.

## Timing
- Reset (async assert): state IDLE; row_q=0, tile_x_q=0, FIFO empty.
- Output values in reset: acc_ready_o=0, ub_wr_en_o=0, ub_wr_addr_o=0, ub_wr_data_o=0, busy_o=0, done_o=0.
- Reset asserted mid-job abandons the job; nothing resumes after deassert.
- start_i at edge N: busy_o=1 from N+1, acc_ready_o may be 1 from N+1.
- With the FIFO:
  - A row accepted at edge N is presented on ub_wr_* from N+1 at the earliest (registered).
  - acc_ready_o = FIFO not full & remaining-to-accept > 0.
  - Simultaneous push and pop on a full FIFO is not allowed; ready is based on registered fullness.
- ub_wr_en_o, ub_wr_addr_o and ub_wr_data_o stay stable while ub_wr_en_o=1 & ub_wr_ready_i=0.
- done_o is asserted the cycle after the last commit edge.

## Configuration
- UB_WRITE_FIFO_EN defined: the FIFO_DEPTH-entry skid FIFO sits between the accumulator and the unified buffer port. Rows can be accepted during unified buffer stalls, up to FIFO_DEPTH outstanding.
- Not defined:
  - Pure pass-through: ub_wr_en_o = acc_valid_i & in WRITE & remaining>0; ub_wr_data_o = acc_data_i; acc_ready_o = ub_wr_ready_i & in WRITE & remaining>0.
  - Zero-cycle latency; FIFO_DEPTH unused.
  - Reset values and the address sequence are unchanged.

## Test plan
- Single tile: start_addr=0x100, U_dim1=3, ITER_dim1=31, ub_wr_ready_i=1, 4 valid rows -> writes at 0x100..0x103 with matching data, then done_o pulses once and busy_o=0.
- Multi tile: start_addr=0x010, U_dim1=1, ITER_dim1=95 -> 6 writes at 0x010..0x015, with tile_x stepping after every 2 rows.
- Wrap: start_addr=0xFFE, U_dim1=3, ITER_dim1=0 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Back-pressure (FIFO on): ub_wr_ready_i=0 for 10 cycles while acc_valid_i=1 -> exactly 4 rows accepted, then acc_ready_o=0. The held write keeps its address and data stable; on release all rows are written in order with none lost.
- Overrun and restart:
  - 3 extra acc_valid_i rows after the job total -> none accepted.
  - start_i while busy -> ignored.
  - A new start_i after done_o -> runs correctly.
- Async reset mid-job (after 2 of 8 writes) -> all outputs 0 immediately. After deassert, no ub_wr_en_o until the next start_i.

Source files
------------

// File: rtl/unified_buffer_write_control_unit.sv
// rtl/unified_buffer_write_control_unit.sv - unified buffer write-back controller, tile-ordered addressing
// Optional skid FIFO between accumulator and UB port: define UB_WRITE_FIFO_EN.
module unified_buffer_write_control_unit #(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [11:0]       start_addr_i,
  input  logic [6:0]        U_dim1_i,
  input  logic [6:0]        ITER_dim1_i,
  input  logic              acc_valid_i,
  input  logic [DATA_W-1:0] acc_data_i,
  output logic              acc_ready_o,
  input  logic              ub_wr_ready_i,
  output logic              ub_wr_en_o,
  output logic [11:0]       ub_wr_addr_o,
  output logic [DATA_W-1:0] ub_wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] start_addr_q, start_addr_d;
  logic [6:0]  u_dim1_q, u_dim1_d;
  logic [1:0]  tile_last_q, tile_last_d;
  logic [9:0]  total_q, total_d;
  logic [9:0]  accepted_q, accepted_d;
  logic [6:0]  row_q, row_d;
  logic [1:0]  tile_x_q, tile_x_d;

  logic        in_write;
  logic        remaining_nz;
  logic        accept;
  logic        commit;
  logic [7:0]  u_rows;
  logic [11:0] tile_base;
  logic [7:0]  rows_in;
  logic [2:0]  tiles_in;
  logic        unused_iter_lsb;

  // Only the tile count (ITER_dim1 >> 5) matters to the write side.
  assign unused_iter_lsb = ^ITER_dim1_i[4:0];

  assign in_write     = (state_q == S_WRITE);
  assign remaining_nz = in_write & (accepted_q < total_q);
  assign accept       = acc_valid_i & acc_ready_o;
  assign commit       = ub_wr_en_o & ub_wr_ready_i;

  assign u_rows       = {1'b0, u_dim1_q} + 8'd1;
  assign tile_base    = {10'd0, tile_x_q} * {4'd0, u_rows};
  assign ub_wr_addr_o = start_addr_q + tile_base + {5'd0, row_q};

  assign rows_in      = {1'b0, U_dim1_i} + 8'd1;
  assign tiles_in     = {1'b0, ITER_dim1_i[6:5]} + 3'd1;

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

`ifdef UB_WRITE_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              fifo_full;

  assign fifo_full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign acc_ready_o  = remaining_nz & ~fifo_full;
  assign ub_wr_en_o   = in_write & (count_q != '0);
  assign ub_wr_data_o = ub_wr_en_o ? fifo_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (commit) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !commit)      count_q <= count_q + 1'b1;
      else if (!accept && commit) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr_q] <= acc_data_i;
  end
`else
  logic unused_cfg;

  assign unused_cfg   = ^FIFO_DEPTH;
  assign acc_ready_o  = remaining_nz & ub_wr_ready_i;
  assign ub_wr_en_o   = remaining_nz & acc_valid_i;
  assign ub_wr_data_o = ub_wr_en_o ? acc_data_i : '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      start_addr_q <= '0;
      u_dim1_q     <= '0;
      tile_last_q  <= '0;
      total_q      <= '0;
      accepted_q   <= '0;
      row_q        <= '0;
      tile_x_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_addr_q <= start_addr_d;
      u_dim1_q     <= u_dim1_d;
      tile_last_q  <= tile_last_d;
      total_q      <= total_d;
      accepted_q   <= accepted_d;
      row_q        <= row_d;
      tile_x_q     <= tile_x_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    u_dim1_d     = u_dim1_q;
    tile_last_d  = tile_last_q;
    total_d      = total_q;
    accepted_d   = accepted_q;
    row_d        = row_q;
    tile_x_d     = tile_x_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          start_addr_d = start_addr_i;
          u_dim1_d     = U_dim1_i;
          tile_last_d  = ITER_dim1_i[6:5];
          total_d      = {2'd0, rows_in} * {7'd0, tiles_in};
          accepted_d   = '0;
          row_d        = '0;
          tile_x_d     = '0;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) accepted_d = accepted_q + 10'd1;
        // Row/tile counters advance on commits, not acceptances, so the address follows the data.
        if (commit) begin
          if (row_q == u_dim1_q) begin
            row_d = '0;
            if (tile_x_q == tile_last_q) state_d = S_DONE;
            else                         tile_x_d = tile_x_q + 2'd1;
          end else begin
            row_d = row_q + 7'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_unified_buffer_write_control_unit.sv
// tb/tb_unified_buffer_write_control_unit.sv - directed bench for the unified buffer write controller
// Expectations for the stall phase depend on UB_WRITE_FIFO_EN.
module tb_unified_buffer_write_control_unit;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [11:0]  start_addr_i;
  logic [6:0]   U_dim1_i;
  logic [6:0]   ITER_dim1_i;
  logic         acc_valid_i;
  logic [255:0] acc_data_i;
  logic         acc_ready_o;
  logic         ub_wr_ready_i;
  logic         ub_wr_en_o;
  logic [11:0]  ub_wr_addr_o;
  logic [255:0] ub_wr_data_o;
  logic         busy_o;
  logic         done_o;

  always #5 clk_i = ~clk_i;

  unified_buffer_write_control_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .U_dim1_i     (U_dim1_i),
    .ITER_dim1_i  (ITER_dim1_i),
    .acc_valid_i  (acc_valid_i),
    .acc_data_i   (acc_data_i),
    .acc_ready_o  (acc_ready_o),
    .ub_wr_ready_i(ub_wr_ready_i),
    .ub_wr_en_o   (ub_wr_en_o),
    .ub_wr_addr_o (ub_wr_addr_o),
    .ub_wr_data_o (ub_wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

`ifdef UB_WRITE_FIFO_EN
  localparam int STALL_ACCEPTS = 4;
`else
  localparam int STALL_ACCEPTS = 0;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  logic [11:0]  q_addr[$];
  logic [255:0] q_data[$];
  int           done_cnt = 0;
  logic [15:0]  cur_tag;

  // Inputs change just after posedge, so a commit seen at negedge is the one taken at the next edge.
  always @(negedge clk_i) begin
    if (rst_i && ub_wr_en_o && ub_wr_ready_i) begin
      q_addr.push_back(ub_wr_addr_o);
      q_data.push_back(ub_wr_data_o);
    end
    if (done_o) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] mk(input logic [15:0] tag, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {8{tag, kk}};
  endfunction

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [11:0] addr, input logic [6:0] u, input logic [6:0] iter);
    @(posedge clk_i); #1;
    start_addr_i = addr;
    U_dim1_i     = u;
    ITER_dim1_i  = iter;
    start_i      = 1'b1;
    @(posedge clk_i); #1;
    start_i      = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input int max_cyc, output int sent);
    logic took;
    sent        = first;
    acc_valid_i = 1'b1;
    acc_data_i  = mk(cur_tag, sent);
    for (int c = 0; c < max_cyc && sent < last; c++) begin
      @(negedge clk_i);
      took = acc_ready_o;
      @(posedge clk_i); #1;
      if (took) begin
        sent++;
        acc_data_i = mk(cur_tag, sent);
      end
    end
    acc_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    check({name, " idle"}, busy_o, 1'b0);
  endtask

  task automatic check_writes(input string name, input logic [11:0] start, input int n);
    logic [11:0] ea;
    check({name, " write count"}, q_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < q_addr.size()) begin
        ea = start + 12'(i);
        check({name, " addr"}, q_addr[i], ea);
        check({name, " data"}, q_data[i], mk(cur_tag, i));
      end
    end
    check({name, " done pulses"}, done_cnt, 1);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, " acc_ready"}, acc_ready_o, 1'b0);
    check({name, " wr_en"}, ub_wr_en_o, 1'b0);
    check({name, " wr_addr"}, ub_wr_addr_o, 12'h000);
    check({name, " wr_data"}, ub_wr_data_o, 256'h0);
    check({name, " busy"}, busy_o, 1'b0);
    check({name, " done"}, done_o, 1'b0);
  endtask

  initial begin
    int          sent;
    int          sent2;
    logic        took;
    logic        have_ref;
    logic        stable;
    logic        en_seen;
    logic [11:0] bp_addr;
    logic [255:0] bp_data;

    rst_i         = 1'b0;
    start_i       = 1'b0;
    start_addr_i  = '0;
    U_dim1_i      = '0;
    ITER_dim1_i   = '0;
    acc_valid_i   = 1'b1;
    acc_data_i    = '1;
    ub_wr_ready_i = 1'b1;
    cur_tag       = 16'h0;
    bp_addr       = '0;
    bp_data       = '0;

    // Reset state, with the accumulator and UB port both offering traffic.
    repeat (3) @(negedge clk_i);
    check_zero_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    check("idle no write", ub_wr_en_o, 1'b0);
    acc_valid_i = 1'b0;

    // Single tile at 0x100.
    cur_tag = 16'h1111;
    clear_log();
    do_start(12'h100, 7'd3, 7'd31);
    check("single busy after start", busy_o, 1'b1);
    feed(0, 4, 20, sent);
    check("single rows accepted", sent, 4);
    wait_idle("single", 10);
    check_writes("single", 12'h100, 4);

    // Three tiles of two rows, a start while busy, and three surplus rows.
    cur_tag = 16'h2222;
    clear_log();
    do_start(12'h010, 7'd1, 7'd95);
    check("multi busy after start", busy_o, 1'b1);
    start_addr_i = 12'h7AA;
    U_dim1_i     = 7'd5;
    ITER_dim1_i  = 7'd0;
    start_i      = 1'b1;
    @(posedge clk_i); #1;
    start_i      = 1'b0;
    feed(0, 9, 30, sent);
    check("multi overrun accepted", sent, 6);
    wait_idle("multi", 10);
    check_writes("multi", 12'h010, 6);

    // Address wrap through 0xFFF.
    cur_tag = 16'h3333;
    clear_log();
    do_start(12'hFFE, 7'd3, 7'd0);
    feed(0, 4, 20, sent);
    check("wrap rows accepted", sent, 4);
    wait_idle("wrap", 10);
    check_writes("wrap", 12'hFFE, 4);

    // UB port stalled for 10 cycles with rows pending.
    cur_tag = 16'h4444;
    clear_log();
    do_start(12'h200, 7'd7, 7'd0);
    ub_wr_ready_i = 1'b0;
    acc_valid_i   = 1'b1;
    sent          = 0;
    acc_data_i    = mk(cur_tag, sent);
    have_ref      = 1'b0;
    stable        = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      took = acc_ready_o;
      if (ub_wr_en_o) begin
        if (!have_ref) begin
          have_ref = 1'b1;
          bp_addr  = ub_wr_addr_o;
          bp_data  = ub_wr_data_o;
        end else if (ub_wr_addr_o !== bp_addr || ub_wr_data_o !== bp_data) begin
          stable = 1'b0;
        end
      end
      @(posedge clk_i); #1;
      if (took) begin
        sent++;
        acc_data_i = mk(cur_tag, sent);
      end
    end
    @(negedge clk_i);
    check("stall acc_ready low", acc_ready_o, 1'b0);
    check("stall rows accepted", sent, STALL_ACCEPTS);
    check("stall write pending", have_ref, 1'b1);
    check("stall held stable", stable, 1'b1);
    check("stall held addr", bp_addr, 12'h200);
    check("stall held data", bp_data, mk(cur_tag, 0));
    @(posedge clk_i); #1;
    ub_wr_ready_i = 1'b1;
    feed(sent, 8, 40, sent2);
    check("stall total accepted", sent2, 8);
    wait_idle("stall", 10);
    check_writes("stall", 12'h200, 8);

    // Asynchronous reset after two of eight writes.
    cur_tag = 16'h5555;
    clear_log();
    do_start(12'h300, 7'd7, 7'd0);
    feed(0, 2, 20, sent);
    repeat (2) @(posedge clk_i);
    #2;
    check("midreset writes before", q_addr.size(), 2);
    acc_valid_i = 1'b1;
    acc_data_i  = mk(cur_tag, 2);
    rst_i       = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk_i);
    rst_i   = 1'b1;
    en_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (ub_wr_en_o || acc_ready_o) en_seen = 1'b1;
    end
    check("midreset no resume", en_seen, 1'b0);
    check("midreset write count", q_addr.size(), 2);
    if (q_addr.size() == 2) check("midreset second addr", q_addr[1], 12'h301);
    check("midreset no done", done_cnt, 0);
    acc_valid_i = 1'b0;

    // Single-row job after the abandoned one.
    cur_tag = 16'h6666;
    clear_log();
    do_start(12'hABC, 7'd0, 7'd0);
    feed(0, 1, 10, sent);
    check("one row accepted", sent, 1);
    wait_idle("one row", 10);
    check_writes("one row", 12'hABC, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
